// File: rtl/cnn_acc_pkg.sv
// ---------------------------------------------------------------------------
// cnn_acc_pkg
// Shared definitions for the accumulate/requantize block:
//   state_t        - FSM state encoding (IDLE, ACC, ROUND, OUT)
//   DEF_DOUT_WIDTH - default result width
//   SAT_MAX/SAT_MIN - saturation bounds for the default result width
//   sat_max/sat_min - saturation bounds for an arbitrary result width
//   rnd_term       - round-half-up term added before the arithmetic shift
// Optional feature macro used by the block: CNN_ACC_BIAS_EN.
// ---------------------------------------------------------------------------
package cnn_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

    // A shift of zero means no fractional bits, so nothing to round.
    function automatic longint rnd_term(input int shift);
        if (shift > 0)
            return longint'(1) <<< (shift - 1);
        return 0;
    endfunction

    localparam int     DEF_DOUT_WIDTH = 14;
    localparam longint SAT_MAX        = sat_max(DEF_DOUT_WIDTH);
    localparam longint SAT_MIN        = sat_min(DEF_DOUT_WIDTH);

endpackage

// File: rtl/cnn_acc_requant_if.sv
// ---------------------------------------------------------------------------
// cnn_acc_requant_if
// Product input channel and result output channel of cnn_acc_requant.
//   prod_din/prod_vld/prod_rdy : signed products in, valid/ready handshake
//   res_dout/res_vld/res_rdy   : signed saturated result out, valid/ready
// Modports: master = upstream/downstream environment, slave = the block.
// ---------------------------------------------------------------------------
interface cnn_acc_requant_if #(
    parameter int DIN_WIDTH  = 23,
    parameter int DOUT_WIDTH = 14
);
    logic signed [DIN_WIDTH-1:0]  prod_din;
    logic                         prod_vld;
    logic                         prod_rdy;
    logic signed [DOUT_WIDTH-1:0] res_dout;
    logic                         res_vld;
    logic                         res_rdy;

    modport master (
        output prod_din, prod_vld, res_rdy,
        input  prod_rdy, res_dout, res_vld
    );

    modport slave (
        input  prod_din, prod_vld, res_rdy,
        output prod_rdy, res_dout, res_vld
    );
endinterface

// File: rtl/cnn_round_sat.sv
// ---------------------------------------------------------------------------
// cnn_round_sat
// Combinational requantizer: adds the round-half-up term, shifts right
// arithmetically by SHIFT and clamps to [SAT_LO, SAT_HI].
//   acc   (in)  : signed accumulator value
//   dout  (out) : signed saturated result
//   clamp (out) : high when the result had to be clamped
// ---------------------------------------------------------------------------
module cnn_round_sat
    import cnn_acc_pkg::*;
#(
    parameter int     ACC_WIDTH  = 27,
    parameter int     DOUT_WIDTH = DEF_DOUT_WIDTH,
    parameter int     SHIFT      = 8,
    parameter longint SAT_HI     = SAT_MAX,
    parameter longint SAT_LO     = SAT_MIN
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         clamp
);
    // One extra bit so adding the rounding term can never wrap.
    localparam int EW = ACC_WIDTH + 1;
    localparam logic signed [EW-1:0] RND = EW'(rnd_term(SHIFT));
    localparam logic signed [EW-1:0] HI  = EW'(SAT_HI);
    localparam logic signed [EW-1:0] LO  = EW'(SAT_LO);

    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] shifted;

    always_comb begin
        sum     = EW'(acc) + RND;
        shifted = sum >>> SHIFT;
        dout    = shifted[DOUT_WIDTH-1:0];
        clamp   = 1'b0;
        if (shifted > HI) begin
            dout  = HI[DOUT_WIDTH-1:0];
            clamp = 1'b1;
        end else if (shifted < LO) begin
            dout  = LO[DOUT_WIDTH-1:0];
            clamp = 1'b1;
        end
    end
endmodule

// File: rtl/cnn_acc_requant.sv
// ---------------------------------------------------------------------------
// cnn_acc_requant
// Accumulates ACC_LEN signed products, then rounds, shifts and saturates the
// sum into a DOUT_WIDTH result held until the downstream accepts it.
//   ap_clk    : clock, rising edge
//   ap_rst_n  : asynchronous active-low reset
//   bias_din  : signed bias, only with CNN_ACC_BIAS_EN defined
//   bus       : cnn_acc_requant_if.slave (product in / result out channels)
//   sat_flag  : sticky, set whenever a result was clamped
//   busy      : high whenever the FSM is not IDLE
// Optional feature macro: CNN_ACC_BIAS_EN.
// ---------------------------------------------------------------------------
module cnn_acc_requant
    import cnn_acc_pkg::*;
#(
    parameter int DIN_WIDTH  = 23,
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
    parameter int ACC_LEN    = 9,
    parameter int ACC_WIDTH  = 27,
    parameter int SHIFT      = 8
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
`ifdef CNN_ACC_BIAS_EN
    input  logic signed [DOUT_WIDTH-1:0] bias_din,
`endif
    cnn_acc_requant_if.slave             bus,
    output logic                         sat_flag,
    output logic                         busy
);
    localparam int CNT_W = $clog2(ACC_LEN + 1);

    // The accumulator headroom only covers 2^(ACC_WIDTH-DIN_WIDTH) products.
    generate
        if (ACC_LEN < 1 || ACC_LEN > (1 << (ACC_WIDTH - DIN_WIDTH))) begin : g_bad_acc_len
            $error("cnn_acc_requant: ACC_LEN out of range for ACC_WIDTH/DIN_WIDTH");
        end
    endgenerate

    state_t                        state;
    state_t                        state_nx;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   load_val;
    logic [CNT_W-1:0]              cnt;
    logic                          prod_rdy_c;
    logic                          prod_fire;
    logic                          last_prod;
    logic signed [DOUT_WIDTH-1:0]  rs_dout;
    logic                          rs_clamp;
    logic signed [DOUT_WIDTH-1:0]  res_q;

    assign prod_ext  = ACC_WIDTH'(bus.prod_din);
    assign prod_fire = bus.prod_vld && prod_rdy_c;
    assign last_prod = (cnt == CNT_W'(ACC_LEN - 1));

    // First product of a group replaces the accumulator, so a previous
    // group never leaks into the next one; the bias is pre-scaled so it
    // lands at unit weight after the final shift.
`ifdef CNN_ACC_BIAS_EN
    assign load_val = prod_ext + (ACC_WIDTH'(bias_din) <<< SHIFT);
`else
    assign load_val = prod_ext;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        prod_rdy_c = 1'b0;
        case (state)
            IDLE: begin
                prod_rdy_c = 1'b1;
                if (bus.prod_vld)
                    state_nx = (ACC_LEN == 1) ? ROUND : ACC;
            end
            ACC: begin
                prod_rdy_c = 1'b1;
                if (bus.prod_vld && last_prod)
                    state_nx = ROUND;
            end
            ROUND:   state_nx = OUT;
            OUT: begin
                if (bus.res_rdy)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            res_q    <= '0;
            sat_flag <= 1'b0;
        end else begin
            if (prod_fire) begin
                if (state == IDLE) begin
                    acc <= load_val;
                    cnt <= CNT_W'(1);
                end else begin
                    acc <= acc + prod_ext;
                    cnt <= cnt + CNT_W'(1);
                end
            end
            if (state == ROUND) begin
                res_q <= rs_dout;
                if (rs_clamp)
                    sat_flag <= 1'b1;
            end
        end
    end

    cnn_round_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DOUT_WIDTH (DOUT_WIDTH),
        .SHIFT      (SHIFT),
        .SAT_HI     (sat_max(DOUT_WIDTH)),
        .SAT_LO     (sat_min(DOUT_WIDTH))
    ) u_round_sat (
        .acc   (acc),
        .dout  (rs_dout),
        .clamp (rs_clamp)
    );

    assign bus.prod_rdy = prod_rdy_c;
    assign bus.res_dout = res_q;
    assign bus.res_vld  = (state == OUT);
    assign busy         = (state != IDLE);
endmodule
